// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared widths, opcodes and sequencer state encoding for the
//            calculator register-file datapath.
// Revision : 1.0  initial release
// ============================================================================
package calc_pkg;

    localparam int CALC_DW = 3;
    localparam int CALC_AW = 2;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EX   = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rf_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_sequencer_if
// Purpose  : Register-file bus between the sequencer (master) and RF (slave).
// Revision : 1.0  initial release
// ============================================================================
interface rf_sequencer_if #(
    parameter int DW = 3,
    parameter int AW = 2
);
    logic          rea;
    logic          reb;
    logic [AW-1:0] raa;
    logic [AW-1:0] rab;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] din;
    logic [DW-1:0] douta;
    logic [DW-1:0] doutb;

    modport master (
        output rea, reb, raa, rab, we, wa, din,
        input  douta, doutb
    );

    modport slave (
        input  rea, reb, raa, rab, we, wa, din,
        output douta, doutb
    );
endinterface
`default_nettype wire

// File: rtl/calc_alu.sv
`default_nettype none
// ============================================================================
// Module   : calc_alu
// Purpose  : Single-cycle ADD/SUB/AND/OR/MOV with carry/borrow flag.
// Revision : 1.0  initial release
// ============================================================================
module calc_alu
    import calc_pkg::*;
#(
    parameter int DW = CALC_DW
) (
    input  wire logic [2:0]    op,
    input  wire logic [DW-1:0] a,
    input  wire logic [DW-1:0] b,
    output logic      [DW-1:0] result,
    output logic               ovf
);

    logic [DW:0] w_sum;
    logic [DW:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, a} + {1'b0, b};
        // MSB of the extended difference is the borrow, i.e. a < b
        w_diff = {1'b0, a} - {1'b0, b};
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = w_sum[DW-1:0];
                ovf    = w_sum[DW];
            end
            OP_SUB: begin
                result = w_diff[DW-1:0];
                ovf    = w_diff[DW];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_MOV:  result = a;
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rf_sequencer
// Purpose  : Issues RF read/execute/write-back for one instruction per go/done.
//            RF_SEQUENCER_MUL_EN enables the multi-cycle shift-add multiply.
// Revision : 1.0  initial release
// ============================================================================
module rf_sequencer
    import calc_pkg::*;
#(
    parameter int DW = CALC_DW,
    parameter int AW = CALC_AW
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          go,
    input  wire logic [2:0]    op,
    input  wire logic [AW-1:0] src_a,
    input  wire logic [AW-1:0] src_b,
    input  wire logic [AW-1:0] dst,
    input  wire logic [DW-1:0] imm,
    output logic               busy,
    output logic               done,
    output logic      [DW-1:0] result,
    output logic               ovf,
    output logic               err,
    rf_sequencer_if.master     rf
);

`ifdef RF_SEQUENCER_MUL_EN
    localparam bit c_mul_en = 1'b1;
    localparam int c_cw     = (DW > 1) ? $clog2(DW) : 1;
    logic [2*DW-1:0] acc_q, acc_d, w_acc_nxt;
    logic [c_cw-1:0] cnt_q, cnt_d;
`else
    localparam bit c_mul_en = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
    logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [DW-1:0] wres_q, wres_d;
    logic          wovf_q, wovf_d;
    logic [DW-1:0] result_q, result_d;
    logic          ovf_q, ovf_d, err_q, err_d;

    logic          w_legal;
    logic [DW-1:0] w_alu_res;
    logic          w_alu_ovf;

    assign w_legal = (op != OP_ILL) && ((op != OP_MUL) || c_mul_en);

    calc_alu #(.DW(DW)) u_alu (
        .op     (op_q),
        .a      (opa_q),
        .b      (opb_q),
        .result (w_alu_res),
        .ovf    (w_alu_ovf)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_d    = dst_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        wres_d   = wres_q;
        wovf_d   = wovf_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
`ifdef RF_SEQUENCER_MUL_EN
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        w_acc_nxt = acc_q + (opb_q[cnt_q] ? ({{DW{1'b0}}, opa_q} << cnt_q) : '0);
`endif
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    op_d    = op;
                    src_a_d = src_a;
                    src_b_d = src_b;
                    dst_d   = dst;
                    if (op == OP_LOAD) begin
                        wres_d  = imm;
                        wovf_d  = 1'b0;
                        state_d = S_WB;
                    end else if (!w_legal) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                opa_d   = rf.douta;
                opb_d   = rf.doutb;
                state_d = S_EX;
`ifdef RF_SEQUENCER_MUL_EN
                acc_d   = '0;
                cnt_d   = '0;
`endif
            end
            S_EX: begin
`ifdef RF_SEQUENCER_MUL_EN
                if (op_q == OP_MUL) begin
                    acc_d  = w_acc_nxt;
                    cnt_d  = cnt_q + 1'b1;
                    wres_d = w_acc_nxt[DW-1:0];
                    wovf_d = |w_acc_nxt[2*DW-1:DW];
                    if (cnt_q == c_cw'(DW-1)) state_d = S_WB;
                end else
`endif
                begin
                    wres_d  = w_alu_res;
                    wovf_d  = w_alu_ovf;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                result_d = wres_q;
                ovf_d    = wovf_q;
                err_d    = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            wres_q   <= '0;
            wovf_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef RF_SEQUENCER_MUL_EN
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            dst_q    <= dst_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            wres_q   <= wres_d;
            wovf_q   <= wovf_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
`ifdef RF_SEQUENCER_MUL_EN
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    // RF strobes decode straight from the state flops so async reset kills them at once
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign ovf    = ovf_q;
    assign err    = err_q;
    assign rf.rea = (state_q == S_RD);
    assign rf.reb = (state_q == S_RD);
    assign rf.raa = src_a_q;
    assign rf.rab = src_b_q;
    assign rf.we  = (state_q == S_WB);
    assign rf.wa  = dst_q;
    assign rf.din = wres_q;

endmodule
`default_nettype wire
